// File: rtl/adder_tree_pkg.sv
// Shared widths and state encoding for the adder-tree accumulator slice.
package adder_tree_pkg;

    localparam int unsigned ADDER_WIDTH = 10;
    localparam int unsigned IN_WIDTH    = ADDER_WIDTH + 1;
    localparam int unsigned CNT_WIDTH   = 8;
    localparam int unsigned ACC_WIDTH   = IN_WIDTH + CNT_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } acc_state_t;

endpackage

// File: rtl/adder_tree_beat_counter.sv
// Loadable down-counter tracking the beats still owed in a frame.
module adder_tree_beat_counter
    import adder_tree_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] load_value,
    input  logic                 decrement,
    output logic                 last
);

    logic [CNT_WIDTH:0] count_q;
    logic [CNT_WIDTH:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            // A zero length encodes the full 2^CNT_WIDTH frame.
            if (load_value == '0) begin
                count_d = {1'b1, {CNT_WIDTH{1'b0}}};
            end else begin
                count_d = {1'b0, load_value};
            end
        end else if (decrement && (count_q != '0)) begin
            count_d = count_q - (CNT_WIDTH+1)'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == (CNT_WIDTH+1)'(1));

endmodule

// File: rtl/adder_tree_accumulator.sv
// Sums a programmable number of adder-tree results into one frame total
// with valid/ready handshakes on input and output.
module adder_tree_accumulator
    import adder_tree_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_sum,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [ACC_WIDTH-1:0] out_sum,
    input  logic                 out_ready,
    output logic                 busy
);

    acc_state_t           state_q;
    acc_state_t           state_d;
    logic [ACC_WIDTH-1:0] acc_q;
    logic [ACC_WIDTH-1:0] acc_d;
    logic [ACC_WIDTH-1:0] out_sum_q;
    logic [ACC_WIDTH-1:0] out_sum_d;
    logic [ACC_WIDTH-1:0] sum_next;
    logic                 cnt_load;
    logic                 cnt_dec;
    logic                 cnt_last;

    adder_tree_beat_counter u_beat_counter (
        .clk        (clk),
        .rst        (rst),
        .load       (cnt_load),
        .load_value (len),
        .decrement  (cnt_dec),
        .last       (cnt_last)
    );

    assign sum_next = acc_q + ACC_WIDTH'(in_sum);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            out_sum_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            out_sum_q <= out_sum_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        out_sum_d = out_sum_q;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d    = '0;
                    cnt_load = 1'b1;
                    state_d  = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d   = sum_next;
                    cnt_dec = 1'b1;
                    if (cnt_last) begin
                        out_sum_d = sum_next;
                        state_d   = DONE;
                    end
                end
            end
            DONE: begin
                // Handshake with start reloads straight into the next frame.
                if (out_ready) begin
                    if (start) begin
                        acc_d    = '0;
                        cnt_load = 1'b1;
                        state_d  = ACCUM;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ACCUM);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        out_sum   = out_sum_q;
    end

endmodule

// File: tb/tb_adder_tree_accumulator.sv
// Directed, table-driven bench for adder_tree_accumulator.
module tb_adder_tree_accumulator;
    import adder_tree_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 start = 1'b0;
    logic [CNT_WIDTH-1:0] len = '0;
    logic                 in_valid = 1'b0;
    logic [IN_WIDTH-1:0]  in_sum = '0;
    logic                 in_ready;
    logic                 out_valid;
    logic [ACC_WIDTH-1:0] out_sum;
    logic                 out_ready = 1'b0;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    adder_tree_accumulator dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_sum    (in_sum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_sum   (out_sum),
        .out_ready (out_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int base;
        int step;
        int nbeats;
        bit bubbles;
        int exp;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int l);
        start = 1'b1;
        len   = CNT_WIDTH'(l);
        tick();
        start = 1'b0;
        check("start_busy", busy, 1);
        check("start_in_ready", in_ready, 1);
        check("start_out_valid", out_valid, 0);
    endtask

    // Feeds base, base+step, ... until nbeats are accepted, then checks the result.
    task automatic feed_beats(input string name, input int base, input int step,
                              input int nbeats, input bit bubbles, input int exp);
        int  accepted = 0;
        int  cyc = 0;
        bit  early = 1'b0;
        while (accepted < nbeats && cyc < 4000) begin
            if (out_valid) early = 1'b1;
            in_valid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_sum   = IN_WIDTH'(base + accepted * step);
            if (in_valid && in_ready) accepted++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        in_sum   = '0;
        check({name, "_beats"}, accepted, nbeats);
        check({name, "_early_done"}, early, 0);
        check({name, "_out_valid"}, out_valid, 1);
        check({name, "_out_sum"}, out_sum, exp);
        check({name, "_in_ready_done"}, in_ready, 0);
        check({name, "_busy_done"}, busy, 1);
    endtask

    task automatic finish_frame(input string name, input int exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({name, "_hs_out_valid"}, out_valid, 0);
        check({name, "_hs_busy"}, busy, 0);
        check({name, "_hs_retained"}, out_sum, exp);
    endtask

    initial begin
        int hs;

        vecs[0] = '{4, 100, 100, 4, 1'b0, 1000};
        vecs[1] = '{0, 2047, 0, 256, 1'b1, 524032};
        vecs[2] = '{3, 1, 2, 3, 1'b0, 9};
        vecs[3] = '{5, 2047, 0, 5, 1'b1, 10235};
        vecs[4] = '{8, 0, 0, 8, 1'b0, 0};
        vecs[5] = '{2, 1024, 1023, 2, 1'b0, 3071};
        vecs[6] = '{1, 2047, 0, 1, 1'b0, 2047};

        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_busy", busy, 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++) begin
            start_frame(vecs[i].len);
            feed_beats($sformatf("vec%0d", i), vecs[i].base, vecs[i].step,
                       vecs[i].nbeats, vecs[i].bubbles, vecs[i].exp);
            finish_frame($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end

        // Single-beat frame held in DONE; start pulses must not disturb it.
        start_frame(1);
        feed_beats("hold", 5, 0, 1, 1'b0, 5);
        for (int k = 0; k < 10; k++) begin
            start = (k % 2 == 0);
            len   = 8'd3;
            tick();
            check("hold_out_valid", out_valid, 1);
            check("hold_out_sum", out_sum, 5);
            check("hold_in_ready", in_ready, 0);
        end
        start = 1'b0;

        // Handshake together with start: back-to-back frame of length 2.
        hs = 0;
        out_ready = 1'b1;
        start = 1'b1;
        len = 8'd2;
        if (out_valid && out_ready) hs++;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        if (out_valid && out_ready) hs++;
        check("b2b_handshakes", hs, 1);
        check("b2b_out_valid", out_valid, 0);
        check("b2b_in_ready", in_ready, 1);
        check("b2b_busy", busy, 1);
        check("b2b_stale_sum", out_sum, 5);
        feed_beats("b2b", 7, 1, 2, 1'b0, 15);
        finish_frame("b2b", 15);
        tick();

        // Reset mid-frame takes effect without a clock edge.
        start_frame(4);
        feed_beats_partial();
        rst = 1'b1;
        #1;
        check("midrst_in_ready", in_ready, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out_sum", out_sum, 0);
        check("midrst_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();
        start_frame(2);
        feed_beats("postrst", 1, 0, 2, 1'b0, 2);
        finish_frame("postrst", 2);
        tick();

        // Valid data while idle must not be absorbed.
        in_valid = 1'b1;
        in_sum   = 11'd99;
        tick();
        tick();
        check("idle_in_ready", in_ready, 0);
        check("idle_busy", busy, 0);
        start = 1'b1;
        len   = 8'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        feed_beats("idle", 3, 0, 1, 1'b0, 3);
        finish_frame("idle", 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    task automatic feed_beats_partial();
        in_valid = 1'b1;
        in_sum   = 11'd10;
        tick();
        in_sum   = 11'd20;
        tick();
        in_valid = 1'b0;
        in_sum   = '0;
        check("partial_in_ready", in_ready, 1);
        check("partial_out_valid", out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
